// File: rtl/video_ctrl_pkg.sv
// Shared definitions for the video-control blocks: sequencer state encoding,
// LED codes and status-word bit positions.
package video_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_START_AI   = 3'd2,
    ST_RUN        = 3'd3,
    ST_DONE       = 3'd4,
    ST_ERROR      = 3'd5
  } state_t;

  localparam logic [2:0] LED_IDLE  = 3'b001;
  localparam logic [2:0] LED_WAIT  = 3'b010;
  localparam logic [2:0] LED_RUN   = 3'b100;
  localparam logic [2:0] LED_ERROR = 3'b111;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_BUSY      = 3;
  localparam int STATUS_ERROR     = 4;
  localparam int STATUS_COUNT_LSB = 16;

  // The accelerator kick and the completion cycle both show as RUN on the LEDs.
  function automatic logic [2:0] led_for(state_t s);
    case (s)
      ST_IDLE:       return LED_IDLE;
      ST_WAIT_FRAME: return LED_WAIT;
      ST_ERROR:      return LED_ERROR;
      default:       return LED_RUN;
    endcase
  endfunction

  function automatic logic is_busy(state_t s);
    return (s == ST_WAIT_FRAME) || (s == ST_START_AI) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// Control/status bundle between the CSR/video side and the inference sequencer.
interface inference_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start_flag;
  logic             repeat_mode;
  logic             abort;
  logic             clear_error;
  logic             frame_start;
  logic             ai_done;
  logic             ai_start;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] frame_count;
  logic [2:0]       led_code;
  logic [31:0]      status_word;

  modport master (
    output start_flag, repeat_mode, abort, clear_error, frame_start, ai_done,
    input  ai_start, busy, error, frame_count, led_code, status_word
  );

  modport slave (
    input  start_flag, repeat_mode, abort, clear_error, frame_start, ai_done,
    output ai_start, busy, error, frame_count, led_code, status_word
  );
endinterface

// File: rtl/inference_sequencer_edge_detect.sv
// One-bit registered rising-edge detector; a held-high input yields one pulse.
module edge_detect_rise (
  input  logic clock_sink_clk,
  input  logic reset_sink_reset,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) sig_d <= 1'b0;
    else                  sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/inference_sequencer.sv
// Per-frame inference sequencer: arms on a start edge, kicks the accelerator on
// the next frame start, then waits for done or timeout.
module inference_sequencer
  import video_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input logic                  clock_sink_clk,
  input logic                  reset_sink_reset,
  inference_sequencer_if.slave bus
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [CNT_W-1:0] frame_count, frame_count_next;
  logic             start_edge;
  logic             busy_q, error_q;
  logic [2:0]       led_q;
  logic [31:0]      status_q, status_next;
  logic [15:0]      count16;

  edge_detect_rise u_start_edge (
    .clock_sink_clk   (clock_sink_clk),
    .reset_sink_reset (reset_sink_reset),
    .sig              (bus.start_flag),
    .rise             (start_edge)
  );

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    state_next       = state;
    timer_next       = timer;
    frame_count_next = frame_count;
    if (bus.abort && state != ST_ERROR) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (start_edge) state_next = ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (bus.frame_start) state_next = ST_START_AI;
        ST_START_AI: begin
          timer_next = '0;
          state_next = ST_RUN;
        end
        ST_RUN: begin
          // Done on the final timeout cycle still counts as success.
          if (bus.ai_done)            state_next = ST_DONE;
          else if (timer == TMR_LAST) state_next = ST_ERROR;
          else                        timer_next = timer + TMR_W'(1);
        end
        ST_DONE: begin
          frame_count_next = frame_count + CNT_W'(1);
          state_next       = bus.repeat_mode ? ST_WAIT_FRAME : ST_IDLE;
        end
        ST_ERROR:      if (bus.clear_error) state_next = ST_IDLE;
        default:       state_next = ST_IDLE;
      endcase
    end
  end

  if (CNT_W >= 16) begin : g_count_trunc
    assign count16 = frame_count_next[15:0];
  end else begin : g_count_ext
    assign count16 = {{(16 - CNT_W){1'b0}}, frame_count_next};
  end

  always_comb begin
    status_next                           = '0;
    status_next[STATUS_COUNT_LSB +: 16]   = count16;
    status_next[STATUS_ERROR]             = (state_next == ST_ERROR);
    status_next[STATUS_BUSY]              = is_busy(state_next);
    status_next[STATUS_STATE_LSB +: 3]    = state_next;
  end

  // Status outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      frame_count <= '0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      led_q       <= LED_IDLE;
      status_q    <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      frame_count <= frame_count_next;
      busy_q      <= is_busy(state_next);
      error_q     <= (state_next == ST_ERROR);
      led_q       <= led_for(state_next);
      status_q    <= status_next;
    end
  end

  assign bus.ai_start    = (state == ST_START_AI);
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;
  assign bus.frame_count = frame_count;
  assign bus.led_code    = led_q;
  assign bus.status_word = status_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model.
module tb_inference_sequencer;

  localparam int TIMEOUT_MAIN  = 64;
  localparam int TIMEOUT_SHORT = 16;
  localparam int P_IDLE = 0, P_WAIT = 1, P_START = 2, P_RUN = 3, P_DONE = 4, P_ERROR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_flag = 1'b0, repeat_mode = 1'b0, abort = 1'b0;
  logic clear_error = 1'b0, frame_start = 1'b0, ai_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_ai_start    = 0;
  int n_ai_start_to = 0;

  // Behavioural model of the main instance
  int m_ph, m_run, m_fc;
  bit m_prev_start;

  always #5 clk = ~clk;

  inference_sequencer_if #(.CNT_W(16)) bus ();
  inference_sequencer_if #(.CNT_W(16)) bus_to ();

  assign bus.start_flag     = start_flag;
  assign bus.repeat_mode    = repeat_mode;
  assign bus.abort          = abort;
  assign bus.clear_error    = clear_error;
  assign bus.frame_start    = frame_start;
  assign bus.ai_done        = ai_done;
  assign bus_to.start_flag  = start_flag;
  assign bus_to.repeat_mode = repeat_mode;
  assign bus_to.abort       = abort;
  assign bus_to.clear_error = clear_error;
  assign bus_to.frame_start = frame_start;
  assign bus_to.ai_done     = ai_done;

  inference_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_MAIN), .CNT_W(16)) u_dut (
    .clock_sink_clk   (clk),
    .reset_sink_reset (rst),
    .bus              (bus)
  );

  inference_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_SHORT), .CNT_W(16)) u_dut_to (
    .clock_sink_clk   (clk),
    .reset_sink_reset (rst),
    .bus              (bus_to)
  );

  always @(posedge clk) begin
    if (bus.ai_start === 1'b1)    n_ai_start++;
    if (bus_to.ai_start === 1'b1) n_ai_start_to++;
  end

  function automatic void model_reset();
    m_ph = P_IDLE; m_run = 0; m_fc = 0; m_prev_start = 1'b0;
  endfunction

  function automatic void model_step();
    bit rise;
    rise = start_flag && !m_prev_start;
    m_prev_start = start_flag;
    if (abort && m_ph != P_ERROR) m_ph = P_IDLE;
    else begin
      case (m_ph)
        P_IDLE:  if (rise) m_ph = P_WAIT;
        P_WAIT:  if (frame_start) m_ph = P_START;
        P_START: begin m_run = 0; m_ph = P_RUN; end
        P_RUN: begin
          m_run++;
          if (ai_done) m_ph = P_DONE;
          else if (m_run >= TIMEOUT_MAIN) m_ph = P_ERROR;
        end
        P_DONE: begin
          m_fc = (m_fc + 1) % 65536;
          m_ph = repeat_mode ? P_WAIT : P_IDLE;
        end
        default: if (clear_error) m_ph = P_IDLE;
      endcase
    end
  endfunction

  function automatic logic [2:0] model_led(int ph);
    case (ph)
      P_IDLE:  return 3'b001;
      P_WAIT:  return 3'b010;
      P_ERROR: return 3'b111;
      default: return 3'b100;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start_flag = 0; repeat_mode = 0; abort = 0;
    clear_error = 0; frame_start = 0; ai_done = 0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.error); end
    total++; if (bus.ai_start !== 1'b0) begin bad++; $display("FAIL reset_ai_start: got %b want 0", bus.ai_start); end
    total++; if (bus.frame_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.frame_count); end
    total++; if (bus.led_code !== 3'b001) begin bad++; $display("FAIL reset_led: got %b want 001", bus.led_code); end
    total++; if (bus.status_word !== 32'd0) begin bad++; $display("FAIL reset_status: got %h want 0", bus.status_word); end
  endtask

  task automatic test_single_run();
    int n0;
    do_reset();
    n0 = n_ai_start;
    start_flag = 1; cycle();
    total++; if (bus.led_code !== 3'b010 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_arm: led=%b busy=%b want led=010 busy=1", bus.led_code, bus.busy); end
    repeat (4) cycle();
    frame_start = 1; cycle(); frame_start = 0;
    total++; if (bus.ai_start !== 1'b1) begin bad++; $display("FAIL single_latency: ai_start=%b want 1", bus.ai_start); end
    repeat (19) cycle();
    ai_done = 1; cycle(); ai_done = 0;
    total++; if (bus.frame_count !== 16'd0) begin bad++; $display("FAIL single_count_early: got %0d want 0", bus.frame_count); end
    cycle();
    total++; if (bus.frame_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", bus.frame_count); end
    total++; if (bus.status_word !== 32'h0001_0000) begin bad++; $display("FAIL single_status: got %h want 00010000", bus.status_word); end
    total++; if (bus.led_code !== 3'b001) begin bad++; $display("FAIL single_led: got %b want 001", bus.led_code); end
    total++; if (n_ai_start - n0 !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", n_ai_start - n0); end
    start_flag = 0;
  endtask

  task automatic test_repeat();
    int n0;
    do_reset();
    n0 = n_ai_start;
    repeat_mode = 1; start_flag = 1; cycle(); start_flag = 0;
    for (int f = 0; f < 3; f++) begin
      repeat (2 + f) cycle();
      frame_start = 1; cycle(); frame_start = 0;
      repeat (5 + 3 * f) cycle();
      ai_done = 1; cycle(); ai_done = 0;
      cycle();
      total++; if (bus.busy !== 1'b1 || bus.led_code !== 3'b010) begin
        bad++; $display("FAIL repeat_rearm%0d: busy=%b led=%b want busy=1 led=010", f, bus.busy, bus.led_code); end
    end
    total++; if (bus.frame_count !== 16'd3) begin bad++; $display("FAIL repeat_count: got %0d want 3", bus.frame_count); end
    total++; if (n_ai_start - n0 !== 3) begin bad++; $display("FAIL repeat_pulses: got %0d want 3", n_ai_start - n0); end
    abort = 1; cycle(); abort = 0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL repeat_abort: busy=%b want 0", bus.busy); end
    repeat_mode = 0;
  endtask

  task automatic test_timeout();
    int n0;
    do_reset();
    n0 = n_ai_start_to;
    start_flag = 1; cycle(); start_flag = 0;
    frame_start = 1; cycle(); frame_start = 0;
    total++; if (bus_to.ai_start !== 1'b1) begin bad++; $display("FAIL timeout_kick: ai_start=%b want 1", bus_to.ai_start); end
    repeat (TIMEOUT_SHORT) cycle();
    total++; if (bus_to.error !== 1'b0 || bus_to.busy !== 1'b1) begin
      bad++; $display("FAIL timeout_early: error=%b busy=%b want error=0 busy=1", bus_to.error, bus_to.busy); end
    cycle();
    total++; if (bus_to.error !== 1'b1 || bus_to.led_code !== 3'b111 || bus_to.status_word[4:0] !== 5'b10101) begin
      bad++; $display("FAIL timeout_error: error=%b led=%b status=%h want 1/111/xxxx0015",
                      bus_to.error, bus_to.led_code, bus_to.status_word); end
    start_flag = 1; cycle(); cycle(); start_flag = 0;
    abort = 1; cycle(); abort = 0;
    total++; if (bus_to.error !== 1'b1 || bus_to.busy !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky: error=%b busy=%b want error=1 busy=0", bus_to.error, bus_to.busy); end
    clear_error = 1; cycle(); clear_error = 0;
    total++; if (bus_to.error !== 1'b0 || bus_to.led_code !== 3'b001 || bus_to.status_word !== 32'd0) begin
      bad++; $display("FAIL timeout_clear: error=%b led=%b status=%h want 0/001/0",
                      bus_to.error, bus_to.led_code, bus_to.status_word); end
    total++; if (n_ai_start_to - n0 !== 1) begin bad++; $display("FAIL timeout_pulses: got %0d want 1", n_ai_start_to - n0); end
  endtask

  task automatic test_abort();
    int n0;
    do_reset();
    start_flag = 1; cycle(); start_flag = 0;
    frame_start = 1; cycle(); frame_start = 0;
    repeat (6) cycle();
    abort = 1; cycle(); abort = 0;
    total++; if (bus.status_word !== 32'd0 || bus.led_code !== 3'b001) begin
      bad++; $display("FAIL abort_run: status=%h led=%b want 0/001", bus.status_word, bus.led_code); end
    ai_done = 1; cycle(); ai_done = 0;
    cycle(); cycle();
    total++; if (bus.frame_count !== 16'd0 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_done_ignored: count=%0d error=%b busy=%b want 0/0/0",
                      bus.frame_count, bus.error, bus.busy); end
    // Abort beats a frame_start arriving in the same cycle.
    n0 = n_ai_start;
    start_flag = 1; cycle(); start_flag = 0;
    abort = 1; frame_start = 1; cycle(); abort = 0; frame_start = 0;
    cycle();
    total++; if (n_ai_start - n0 !== 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_wait: pulses=%0d busy=%b want 0/0", n_ai_start - n0, bus.busy); end
  endtask

  task automatic test_level_start();
    int n0;
    do_reset();
    n0 = n_ai_start;
    start_flag = 1;
    for (int i = 0; i < 100; i++) begin
      frame_start = (i % 20 == 5);
      ai_done     = (i % 20 == 10);
      cycle();
    end
    frame_start = 0; ai_done = 0; start_flag = 0;
    total++; if (n_ai_start - n0 !== 1) begin bad++; $display("FAIL level_pulses: got %0d want 1", n_ai_start - n0); end
    total++; if (bus.frame_count !== 16'd1) begin bad++; $display("FAIL level_count: got %0d want 1", bus.frame_count); end
  endtask

  task automatic test_reset_mid_run();
    int n0;
    do_reset();
    n0 = n_ai_start;
    start_flag = 1; cycle(); start_flag = 0;
    frame_start = 1; cycle(); frame_start = 0;
    repeat (3) cycle();
    ai_done = 1; cycle(); ai_done = 0;
    cycle();
    start_flag = 1; cycle();
    frame_start = 1; cycle(); frame_start = 0;
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.error !== 1'b0 || bus.ai_start !== 1'b0 || bus.frame_count !== 16'd0 ||
                 bus.led_code !== 3'b001 || bus.status_word !== 32'd0) begin
      bad++; $display("FAIL reset_mid_run: busy=%b error=%b ai_start=%b count=%0d led=%b status=%h want reset values",
                      bus.busy, bus.error, bus.ai_start, bus.frame_count, bus.led_code, bus.status_word); end
    model_reset();
    start_flag = 0;
    frame_start = 1; ai_done = 1;
    @(negedge clk);
    frame_start = 0; ai_done = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cycle();
    total++; if (n_ai_start - n0 !== 2 || bus.frame_count !== 16'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_after: pulses=%0d count=%0d busy=%b want 2/0/0",
                      n_ai_start - n0, bus.frame_count, bus.busy); end
  endtask

  task automatic test_random();
    logic        exp_busy, exp_err, exp_ai;
    logic [31:0] exp_status;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start_flag = ~start_flag;
      if ($urandom_range(0, 7) == 0) repeat_mode = ~repeat_mode;
      abort       = ($urandom_range(0, 60) == 0);
      clear_error = ($urandom_range(0, 15) == 0);
      frame_start = ($urandom_range(0, 6) == 0);
      ai_done     = ($urandom_range(0, 40) == 0);
      cycle();
      exp_busy   = (m_ph == P_WAIT) || (m_ph == P_START) || (m_ph == P_RUN);
      exp_err    = (m_ph == P_ERROR);
      exp_ai     = (m_ph == P_START);
      exp_status = (32'(m_fc) << 16) | (32'(exp_err) << 4) | (32'(exp_busy) << 3) | 32'(m_ph);
      total++; if (bus.status_word !== exp_status) begin
        bad++; $display("FAIL rand_status @%0d: got %h want %h", i, bus.status_word, exp_status); end
      total++; if (bus.led_code !== model_led(m_ph)) begin
        bad++; $display("FAIL rand_led @%0d: got %b want %b", i, bus.led_code, model_led(m_ph)); end
      total++; if (bus.ai_start !== exp_ai) begin
        bad++; $display("FAIL rand_ai_start @%0d: got %b want %b", i, bus.ai_start, exp_ai); end
      total++; if (bus.frame_count !== 16'(m_fc)) begin
        bad++; $display("FAIL rand_count @%0d: got %0d want %0d", i, bus.frame_count, m_fc); end
      total++; if (bus.busy !== exp_busy || bus.error !== exp_err) begin
        bad++; $display("FAIL rand_flags @%0d: busy=%b error=%b want %b/%b", i, bus.busy, bus.error, exp_busy, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_repeat();
    test_timeout();
    test_abort();
    test_level_start();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
